// File: rtl/csr_wport_arb_if.sv
// Bundled signals between csr_wport_arb and its neighbours. The arbiter connects
// through the slave modport; whatever drives the EX, trap and read inputs uses the master modport.
interface csr_wport_arb_if #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          ex_we_i;
    logic [AW-1:0] ex_waddr_i;
    logic [DW-1:0] ex_wdata_i;
    logic          int_we_i;
    logic [AW-1:0] int_waddr_i;
    logic [DW-1:0] int_wdata_i;
    logic [AW-1:0] raddr_i;
    logic [DW-1:0] rdata_i;
    logic [DW-1:0] rdata_o;
    logic          csr_we_o;
    logic [AW-1:0] csr_waddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic          hold_flag_o;
    logic [CW-1:0] pend_cnt_o;
    logic          ovf_o;

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output int_we_i, int_waddr_i, int_wdata_i,
        output raddr_i, rdata_i,
        input  rdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  hold_flag_o, pend_cnt_o, ovf_o
    );

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  int_we_i, int_waddr_i, int_wdata_i,
        input  raddr_i, rdata_i,
        output rdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output hold_flag_o, pend_cnt_o, ovf_o
    );
endinterface

// File: rtl/csr_wport_arb.sv
// CSR write-port arbiter: trap writes win, losing EX writes queue in an in-order
// shift buffer, and EX reads are forwarded from writes not yet in csr_reg.
module csr_wport_arb #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    csr_wport_arb_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_A = CW'(DEPTH - 1);
    localparam logic [CW-1:0] HOLD_B = CW'(DEPTH - 2);

    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_buf_addr [DEPTH];
    logic [DW-1:0] r_buf_data [DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_wr_idx;
    logic          w_nxt_we;
    logic [AW-1:0] w_nxt_addr;
    logic [DW-1:0] w_nxt_data;
    logic [DW-1:0] w_rdata;

    always_comb begin
        w_empty    = (r_cnt == '0);
        w_full     = (r_cnt == FULL);
        w_pop      = !bus.int_we_i && !w_empty;
        w_bypass   = !bus.int_we_i && w_empty && bus.ex_we_i;
        w_push_req = bus.ex_we_i && !w_bypass;
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        // Entry 0 is the oldest; a pop shifts everything down, so the push slot moves with it.
        w_wr_idx   = w_pop ? (r_cnt - CW'(1)) : r_cnt;

        w_nxt_we   = 1'b0;
        w_nxt_addr = '0;
        w_nxt_data = '0;
        if (bus.int_we_i) begin
            w_nxt_we   = 1'b1;
            w_nxt_addr = bus.int_waddr_i;
            w_nxt_data = bus.int_wdata_i;
        end else if (w_pop) begin
            w_nxt_we   = 1'b1;
            w_nxt_addr = r_buf_addr[0];
            w_nxt_data = r_buf_data[0];
        end else if (w_bypass) begin
            w_nxt_we   = 1'b1;
            w_nxt_addr = bus.ex_waddr_i;
            w_nxt_data = bus.ex_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_ovf   <= r_ovf | w_drop;
            r_we    <= w_nxt_we;
            r_waddr <= w_nxt_addr;
            r_wdata <= w_nxt_data;
        end
    end

    // Buffer contents need no reset: validity is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                r_buf_addr[i] <= r_buf_addr[i+1];
                r_buf_data[i] <= r_buf_data[i+1];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_push && (CW'(i) == w_wr_idx)) begin
                r_buf_addr[i] <= bus.ex_waddr_i;
                r_buf_data[i] <= bus.ex_wdata_i;
            end
        end
    end

    // Later matches override earlier ones, so the newest buffered write wins.
    always_comb begin
        w_rdata = bus.rdata_i;
        if (r_we && (r_waddr == bus.raddr_i)) begin
            w_rdata = r_wdata;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_cnt) && (r_buf_addr[i] == bus.raddr_i)) begin
                w_rdata = r_buf_data[i];
            end
        end
    end

    assign bus.rdata_o     = w_rdata;
    assign bus.csr_we_o    = r_we;
    assign bus.csr_waddr_o = r_waddr;
    assign bus.csr_wdata_o = r_wdata;
    assign bus.pend_cnt_o  = r_cnt;
    assign bus.ovf_o       = r_ovf;
    assign bus.hold_flag_o = (r_cnt >= HOLD_A) || (bus.int_we_i && (r_cnt >= HOLD_B));
endmodule

// File: tb/tb_csr_wport_arb.sv
// Self-checking bench for csr_wport_arb: a queue-based reference model is compared
// every cycle, with directed scenarios pinned by literal expectations.
module tb_csr_wport_arb;
    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rst;

    csr_wport_arb_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    csr_wport_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_ovf;
    bit            m_valid = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: trap first, then oldest queued EX write, then EX bypass.
    task automatic model_update();
        ent_t e;
        if (rst) begin
            q.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0;
            m_valid = 1;
            return;
        end
        if (!m_valid) return;
        e.a = bus.ex_waddr_i;
        e.d = bus.ex_wdata_i;
        if (bus.int_we_i) begin
            m_we = 1; m_addr = bus.int_waddr_i; m_data = bus.int_wdata_i;
            if (bus.ex_we_i) begin
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1;
            end
        end else if (q.size() > 0) begin
            ent_t o;
            o = q.pop_front();
            m_we = 1; m_addr = o.a; m_data = o.d;
            if (bus.ex_we_i) q.push_back(e);
        end else if (bus.ex_we_i) begin
            m_we = 1; m_addr = e.a; m_data = e.d;
        end else begin
            m_we = 0; m_addr = '0; m_data = '0;
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] exp_rd;
        bit            exp_hold;
        bit            found;
        int            sz;
        if (!m_valid) return;
        sz = q.size();
        exp_hold = (sz >= DEPTH - 1) || (bus.int_we_i && (sz >= DEPTH - 2));
        found = 0;
        exp_rd = bus.rdata_i;
        for (int i = sz - 1; i >= 0; i--) begin
            if (!found && q[i].a == bus.raddr_i) begin
                exp_rd = q[i].d;
                found = 1;
            end
        end
        if (!found && m_we && m_addr == bus.raddr_i) exp_rd = m_data;
        check("csr_we",   64'(bus.csr_we_o),    64'(m_we));
        check("csr_waddr",64'(bus.csr_waddr_o), 64'(m_addr));
        check("csr_wdata",64'(bus.csr_wdata_o), 64'(m_data));
        check("pend_cnt", 64'(bus.pend_cnt_o),  64'(sz));
        check("ovf",      64'(bus.ovf_o),       64'(m_ovf));
        check("hold",     64'(bus.hold_flag_o), 64'(exp_hold));
        check("rdata",    64'(bus.rdata_o),     64'(exp_rd));
    endtask

    // Inputs are driven at posedge+1; combinational outputs are compared at the negedge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input logic iw, input logic [AW-1:0] ia, input logic [DW-1:0] id);
        bus.ex_we_i  = ew; bus.ex_waddr_i  = ea; bus.ex_wdata_i  = ed;
        bus.int_we_i = iw; bus.int_waddr_i = ia; bus.int_wdata_i = id;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, '0, '0);
    endtask

    logic [AW-1:0] addr_set [4];

    initial begin
        addr_set[0] = 32'h300; addr_set[1] = 32'h341;
        addr_set[2] = 32'h342; addr_set[3] = 32'h305;
        rst = 1'b1;
        idle();
        bus.raddr_i = 32'h0; bus.rdata_i = 32'h0;
        @(posedge clk); model_update(); #1;
        cyc();
        rst = 1'b0;
        #1;
        check("reset csr_we", 64'(bus.csr_we_o), 64'd0);
        check("reset pend",   64'(bus.pend_cnt_o), 64'd0);
        check("reset ovf",    64'(bus.ovf_o), 64'd0);
        check("reset hold",   64'(bus.hold_flag_o), 64'd0);
        cyc();

        // Single EX write on an empty buffer: bypass.
        drive(1, 32'h341, 32'h8000_0010, 0, '0, '0);
        cyc();
        idle(); #1;
        check("single we",    64'(bus.csr_we_o), 64'd1);
        check("single addr",  64'(bus.csr_waddr_o), 64'h341);
        check("single data",  64'(bus.csr_wdata_o), 64'h8000_0010);
        check("single pend",  64'(bus.pend_cnt_o), 64'd0);
        cyc(); #1;
        check("single we off", 64'(bus.csr_we_o), 64'd0);
        cyc();

        // Collision: trap wins, EX queues.
        drive(1, 32'h300, 32'h88, 1, 32'h341, 32'h100);
        cyc();
        idle(); #1;
        check("coll addr0", 64'(bus.csr_waddr_o), 64'h341);
        check("coll data0", 64'(bus.csr_wdata_o), 64'h100);
        check("coll pend0", 64'(bus.pend_cnt_o), 64'd1);
        cyc(); #1;
        check("coll addr1", 64'(bus.csr_waddr_o), 64'h300);
        check("coll data1", 64'(bus.csr_wdata_o), 64'h88);
        check("coll pend1", 64'(bus.pend_cnt_o), 64'd0);
        cyc();

        // Same address: trap 0xA then EX 0xB; reads must see 0xB.
        bus.raddr_i = 32'h341; bus.rdata_i = 32'h5555;
        drive(1, 32'h341, 32'hB, 1, 32'h341, 32'hA);
        cyc();
        idle(); #1;
        check("same data0", 64'(bus.csr_wdata_o), 64'hA);
        check("same rd1",   64'(bus.rdata_o), 64'hB);
        cyc(); #1;
        check("same data1", 64'(bus.csr_wdata_o), 64'hB);
        check("same rd2",   64'(bus.rdata_o), 64'hB);
        cyc(); cyc();

        // Trap burst of 3 with 2 EX writes.
        drive(1, 32'h305, 32'h11, 1, 32'h341, 32'h1000);
        cyc();
        drive(1, 32'h342, 32'h22, 1, 32'h300, 32'h1800); #1;
        check("burst hold", 64'(bus.hold_flag_o), 64'd1);
        cyc();
        drive(0, '0, '0, 1, 32'h342, 32'hB); #1;
        check("burst pend2", 64'(bus.pend_cnt_o), 64'd2);
        cyc();
        idle(); #1;
        check("burst last trap", 64'(bus.csr_wdata_o), 64'hB);
        cyc(); #1;
        check("burst drain0", 64'(bus.csr_wdata_o), 64'h11);
        cyc(); #1;
        check("burst drain1", 64'(bus.csr_wdata_o), 64'h22);
        check("burst ovf",    64'(bus.ovf_o), 64'd0);
        cyc();

        // Overflow: third EX write under trap traffic is dropped.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h300, 32'h40 + k, 1, 32'h341, 32'h200 + k);
            cyc();
        end
        drive(0, '0, '0, 1, 32'h341, 32'h300); #1;
        check("ovf set",  64'(bus.ovf_o), 64'd1);
        check("ovf pend", 64'(bus.pend_cnt_o), 64'd2);
        cyc();

        // Reset mid-drain with a full buffer.
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        check("rst we",   64'(bus.csr_we_o), 64'd0);
        check("rst pend", 64'(bus.pend_cnt_o), 64'd0);
        check("rst ovf",  64'(bus.ovf_o), 64'd0);
        cyc(); #1;
        check("rst no stale", 64'(bus.csr_we_o), 64'd0);
        cyc();

        // Randomized traffic, EX ignoring hold, occasional reset.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) < 55), addr_set[$urandom_range(0, 3)], $urandom(),
                  ($urandom_range(0, 99) < 30), addr_set[$urandom_range(0, 3)], $urandom());
            bus.raddr_i = addr_set[$urandom_range(0, 3)];
            bus.rdata_i = $urandom();
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
